// File: rtl/fifo_ptr_ctrl_pkg.sv
// fifo_ptr_pkg: shared types and helpers for the async FIFO pointer logic.
//   ptr_mode_e     : selects write-side (full) or read-side (empty) behaviour
//   DEF_ADDR_WIDTH : default memory address width
//   bin2gray       : binary to reflected Gray code (callers truncate to width)
package fifo_ptr_pkg;

    typedef enum logic {
        PTR_WR = 1'b0,
        PTR_RD = 1'b1
    } ptr_mode_e;

    localparam int DEF_ADDR_WIDTH = 4;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_gray2bin.sv
// gray2bin: purely combinational Gray-to-binary converter.
//   i_gray : Gray-coded input, WIDTH bits
//   o_bin  : binary equivalent, WIDTH bits
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: single-clock-domain pointer and flag controller for one side
// of an async FIFO (write side reports full, read side reports empty).
//   clk, rst_n    : domain clock, asynchronous active-low reset
//   inc           : advance request (write or read strobe)
//   remote_gptr   : opposite side's Gray pointer, already synchronised to clk
//   clr_err       : clears the sticky error flag
//   adr           : memory address (low bits of binary pointer)
//   ptr           : registered Gray pointer for the other domain's synchroniser
//   status        : full (PTR_WR) / empty (PTR_RD), registered
//   almost        : almost-full / almost-empty, registered
//   level         : registered occupancy, 0..DEPTH
//   err           : sticky, set by inc while status is high
module fifo_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int        ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter ptr_mode_e MODE          = PTR_WR,
    parameter int        ALMOST_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc,
    input  logic [ADDR_WIDTH:0]   remote_gptr,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] adr,
    output logic [ADDR_WIDTH:0]   ptr,
    output logic                  status,
    output logic                  almost,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  err
);

    localparam int   PW       = ADDR_WIDTH + 1;
    localparam int   DEPTH    = 1 << ADDR_WIDTH;
    // Read side comes out of reset empty and almost-empty.
    localparam logic RST_FLAG = (MODE == PTR_RD);

    if (ADDR_WIDTH < 2 || ALMOST_THRESH < 1 || ALMOST_THRESH > DEPTH - 1) begin : g_bad_param
        $error("fifo_ptr_ctrl: ADDR_WIDTH must be >= 2 and ALMOST_THRESH in 1..DEPTH-1");
    end

    logic [PW-1:0] r_bin, r_gptr, r_level;
    logic          r_status, r_almost, r_err;

    logic [PW-1:0] w_bnext, w_gnext, w_rbin, w_level_next;
    logic          w_status_next, w_almost_next, w_viol;

    // A blocked inc leaves the pointer alone; the same condition sets err.
    assign w_viol  = inc & r_status;
    assign w_bnext = r_bin + PW'(inc & ~r_status);
    assign w_gnext = PW'(bin2gray(32'(w_bnext)));

    gray2bin #(.WIDTH(PW)) u_g2b (
        .i_gray (remote_gptr),
        .o_bin  (w_rbin)
    );

    if (MODE == PTR_WR) begin : g_wr
        // Full when we are exactly one lap ahead: top two Gray bits inverted.
        assign w_status_next = (w_gnext == {~remote_gptr[ADDR_WIDTH -: 2],
                                            remote_gptr[ADDR_WIDTH-2:0]});
        assign w_level_next  = w_bnext - w_rbin;
        assign w_almost_next = (w_level_next >= PW'(DEPTH - ALMOST_THRESH));
    end else begin : g_rd
        assign w_status_next = (w_gnext == remote_gptr);
        assign w_level_next  = w_rbin - w_bnext;
        assign w_almost_next = (w_level_next <= PW'(ALMOST_THRESH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin    <= '0;
            r_gptr   <= '0;
            r_level  <= '0;
            r_status <= RST_FLAG;
            r_almost <= RST_FLAG;
            r_err    <= 1'b0;
        end else begin
            r_bin    <= w_bnext;
            r_gptr   <= w_gnext;
            r_level  <= w_level_next;
            r_status <= w_status_next;
            r_almost <= w_almost_next;
            // A new violation wins over a simultaneous clear.
            r_err    <= w_viol | (r_err & ~clr_err);
        end
    end

    assign adr    = r_bin[ADDR_WIDTH-1:0];
    assign ptr    = r_gptr;
    assign status = r_status;
    assign almost = r_almost;
    assign level  = r_level;
    assign err    = r_err;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
module tb_fifo_ptr_ctrl;
    import fifo_ptr_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // write-side instance
    logic       wi, wc;
    logic [3:0] wrem;
    logic [2:0] wadr;
    logic [3:0] wptr, wlvl;
    logic       wst, wal, werr;
    // read-side instance
    logic       ri, rc;
    logic [3:0] rrem;
    logic [2:0] radr;
    logic [3:0] rptr, rlvl;
    logic       rst_o, ral, rerr;

    fifo_ptr_ctrl #(.ADDR_WIDTH(3), .MODE(PTR_WR), .ALMOST_THRESH(2)) u_wr (
        .clk(clk), .rst_n(rst_n), .inc(wi), .remote_gptr(wrem), .clr_err(wc),
        .adr(wadr), .ptr(wptr), .status(wst), .almost(wal), .level(wlvl), .err(werr)
    );
    fifo_ptr_ctrl #(.ADDR_WIDTH(3), .MODE(PTR_RD), .ALMOST_THRESH(2)) u_rd (
        .clk(clk), .rst_n(rst_n), .inc(ri), .remote_gptr(rrem), .clr_err(rc),
        .adr(radr), .ptr(rptr), .status(rst_o), .almost(ral), .level(rlvl), .err(rerr)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Gray code of a count modulo 16, straight from the definition.
    function automatic logic [3:0] g4(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic idle_inputs();
        wi = 0; wc = 0; wrem = 4'd0;
        ri = 0; rc = 0; rrem = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_wadr"}, int'(wadr), 0);
        chk({tag, "_wptr"}, int'(wptr), 0);
        chk({tag, "_wlvl"}, int'(wlvl), 0);
        chk({tag, "_wst"},  int'(wst), 0);
        chk({tag, "_wal"},  int'(wal), 0);
        chk({tag, "_werr"}, int'(werr), 0);
        chk({tag, "_rptr"}, int'(rptr), 0);
        chk({tag, "_rlvl"}, int'(rlvl), 0);
        chk({tag, "_rst"},  int'(rst_o), 1);
        chk({tag, "_ral"},  int'(ral), 1);
        chk({tag, "_rerr"}, int'(rerr), 0);
    endtask

    typedef struct {
        logic       inc;
        logic       clr;
        logic [3:0] rem;
        logic [3:0] ptr;
        logic       st;
        logic       al;
        logic [3:0] lvl;
        logic       err;
    } vec_t;

    vec_t       tbl[12];
    logic [3:0] fill_seq[8];

    initial begin
        // write-side fill then overflow, remote read pointer parked at 0
        fill_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                     4'b0111, 4'b0101, 4'b0100, 4'b1100};
        for (int i = 0; i < 8; i++)
            tbl[i] = '{inc: 1, clr: 0, rem: 4'd0, ptr: fill_seq[i], st: (i == 7),
                       al: (i + 1 >= 6), lvl: 4'(i + 1), err: 0};
        tbl[8]  = '{inc: 1, clr: 0, rem: 4'd0, ptr: 4'b1100, st: 1, al: 1, lvl: 4'd8, err: 1};
        tbl[9]  = '{inc: 1, clr: 0, rem: 4'd0, ptr: 4'b1100, st: 1, al: 1, lvl: 4'd8, err: 1};
        tbl[10] = '{inc: 1, clr: 1, rem: 4'd0, ptr: 4'b1100, st: 1, al: 1, lvl: 4'd8, err: 1};
        tbl[11] = '{inc: 0, clr: 1, rem: 4'd0, ptr: 4'b1100, st: 1, al: 1, lvl: 4'd8, err: 0};

        // ---- reset held low, then released
        idle_inputs();
        rst_n = 0;
        repeat (3) begin
            tick();
            chk_reset_vals("rst_hold");
        end
        rst_n = 1;
        tick();
        chk_reset_vals("rst_idle");

        // ---- table-driven fill and overflow
        foreach (tbl[i]) begin
            wi = tbl[i].inc; wc = tbl[i].clr; wrem = tbl[i].rem;
            tick();
            chk($sformatf("tbl%0d_ptr", i), int'(wptr), int'(tbl[i].ptr));
            chk($sformatf("tbl%0d_st", i),  int'(wst),  int'(tbl[i].st));
            chk($sformatf("tbl%0d_al", i),  int'(wal),  int'(tbl[i].al));
            chk($sformatf("tbl%0d_lvl", i), int'(wlvl), int'(tbl[i].lvl));
            chk($sformatf("tbl%0d_err", i), int'(werr), int'(tbl[i].err));
        end

        // ---- asynchronous reset in the middle of operation
        do_reset();
        wi = 1;
        repeat (5) tick();
        chk("pre_async_wlvl", int'(wlvl), 5);
        #3 rst_n = 0;
        #1 chk_reset_vals("rst_async");
        wi = 0;
        @(negedge clk);
        rst_n = 1;
        tick();

        // ---- read-side drain, then lap wrap
        do_reset();
        rrem = g4(8);
        tick();
        chk("rd_load_lvl", int'(rlvl), 8);
        chk("rd_load_st", int'(rst_o), 0);
        for (int i = 0; i < 8; i++) begin
            ri = 1;
            tick();
            chk($sformatf("rd_drain%0d_lvl", i), int'(rlvl), 7 - i);
            chk($sformatf("rd_drain%0d_al", i), int'(ral), int'((7 - i) <= 2));
            chk($sformatf("rd_drain%0d_st", i), int'(rst_o), int'(i == 7));
            chk($sformatf("rd_drain%0d_ptr", i), int'(rptr), int'(g4(i + 1)));
        end
        ri = 0;
        rrem = 4'b0000;
        tick();
        chk("rd_wrap_lvl", int'(rlvl), 8);
        chk("rd_wrap_st", int'(rst_o), 0);
        for (int i = 0; i < 8; i++) begin
            logic [3:0] prev;
            prev = rptr;
            ri = 1;
            tick();
            chk($sformatf("rd_wrap%0d_1bit", i), $countones(prev ^ rptr), 1);
            chk($sformatf("rd_wrap%0d_adr", i), int'(radr), (i + 1) % 8);
        end
        ri = 0;
        chk("rd_wrap_final_ptr", int'(rptr), 0);
        chk("rd_wrap_final_st", int'(rst_o), 1);
        chk("rd_wrap_final_err", int'(rerr), 0);

        // ---- concurrent local write and remote read at level 7
        do_reset();
        wi = 1;
        repeat (7) tick();
        chk("sim_pre_lvl", int'(wlvl), 7);
        wi = 1; wrem = g4(1);
        tick();
        wi = 0;
        chk("sim_lvl", int'(wlvl), 7);
        chk("sim_st", int'(wst), 0);

        // ---- randomized streams against a count-based model
        do_reset();
        begin
            int  mw = 0, mrc = 0, mr = 0, mwc = 0;
            bit  mwfull = 0, mwerr = 0, mrempty = 1, mrerr = 0;
            logic [3:0] pwp, prp, pwrem, prrem;
            logic pwst, prst;
            for (int c = 0; c < 600; c++) begin
                int ph_inc;
                ph_inc = (c < 300) ? 3 : 1;
                pwp = wptr; prp = rptr; pwst = wst; prst = rst_o;
                pwrem = wrem; prrem = rrem;
                // write side: local writes, remote reads trailing behind
                wi = ($urandom_range(0, 3) < ph_inc);
                wc = ($urandom_range(0, 15) == 0);
                if (mrc < mw && $urandom_range(0, 3) < 4 - ph_inc) mrc++;
                wrem = g4(mrc);
                // read side: local reads, remote writes at most one lap ahead
                ri = ($urandom_range(0, 3) >= ph_inc);
                rc = ($urandom_range(0, 15) == 0);
                if (mwc < mr + 8 && $urandom_range(0, 3) < ph_inc) mwc++;
                rrem = g4(mwc);
                // model: occupancy is writes minus reads
                mwerr = (wi && mwfull) || (mwerr && !wc);
                if (wi && !mwfull) mw++;
                mwfull = (mw - mrc == 8);
                mrerr = (ri && mrempty) || (mrerr && !rc);
                if (ri && !mrempty) mr++;
                mrempty = (mwc - mr == 0);
                tick();
                chk("rnd_wlvl", int'(wlvl), mw - mrc);
                chk("rnd_wst",  int'(wst), int'(mwfull));
                chk("rnd_wal",  int'(wal), int'(mw - mrc >= 6));
                chk("rnd_wptr", int'(wptr), int'(g4(mw)));
                chk("rnd_wadr", int'(wadr), mw % 8);
                chk("rnd_werr", int'(werr), int'(mwerr));
                chk("rnd_rlvl", int'(rlvl), mwc - mr);
                chk("rnd_rst",  int'(rst_o), int'(mrempty));
                chk("rnd_ral",  int'(ral), int'(mwc - mr <= 2));
                chk("rnd_rptr", int'(rptr), int'(g4(mr)));
                chk("rnd_radr", int'(radr), mr % 8);
                chk("rnd_rerr", int'(rerr), int'(mrerr));
                chk("rnd_w1bit", int'($countones(pwp ^ wptr) <= 1), 1);
                chk("rnd_r1bit", int'($countones(prp ^ rptr) <= 1), 1);
                chk("rnd_wlvl_max", int'(wlvl <= 4'd8), 1);
                if (pwst && !wst) chk("rnd_wst_drop_needs_remote", int'(pwrem != wrem), 1);
                if (prst && !rst_o) chk("rnd_rst_drop_needs_remote", int'(prrem != rrem), 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ptr_ctrl.md
# fifo_ptr_ctrl

Parametrised single-domain pointer/flag controller for the async FIFO. One instance runs in the write domain and one in the read domain. Each instance:
- holds the binary and Gray pointer for its side;
- gates increments on its own full/empty status;
- compares against the opposite side's Gray pointer (already synchronised into this clock domain outside the block);
- produces full/empty, almost-full/almost-empty, a fill level, and a sticky overflow/underflow error.

## Interface
Parameters:
- ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- MODE, PTR_WR, PTR_WR = write side (status means full), PTR_RD = read side (status means empty).
- ALMOST_THRESH, 2, almost-flag margin; legal range 1..DEPTH-1, checked at elaboration.

Ports:
- clk  in  1  domain clock.
- rst_n  in  1  asynchronous active-low reset.
- inc  in  1  request to advance pointer (write or read strobe).
- remote_gptr  in  ADDR_WIDTH+1  opposite-side Gray pointer, already synchronised to clk.
- clr_err  in  1  clears sticky err.
- adr  out  ADDR_WIDTH  memory address, low bits of binary pointer.
- ptr  out  ADDR_WIDTH+1  registered Gray pointer, sent to the other domain's synchroniser.
- status  out  1  full (PTR_WR) or empty (PTR_RD), registered.
- almost  out  1  almost-full (PTR_WR) or almost-empty (PTR_RD), registered.
- level  out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH.
- err  out  1  sticky: inc seen while status high.

## Operation
- Next-state values:
  - bnext = bin + (inc & ~status), modulo 2*DEPTH.
  - gnext = bnext ^ (bnext >> 1).
  - rbin = Gray-to-binary of remote_gptr.
- PTR_WR:
  - full_next = (gnext == {~remote_gptr[MSB:MSB-1], remote_gptr[MSB-2:0]}).
  - level_next = bnext - rbin (mod 2*DEPTH).
  - almost_next = level_next >= DEPTH - ALMOST_THRESH.
- PTR_RD:
  - empty_next = (gnext == remote_gptr).
  - level_next = rbin - bnext.
  - almost_next = level_next <= ALMOST_THRESH.
- Registers: bin, ptr, status, almost, level and err all load on every clk rising edge.
- inc while status=1: the pointer holds and err sets.
- err priority: set beats clr_err in the same cycle. err holds until clr_err is applied in a cycle with no new violation.
- Reset values, forced immediately on rst_n low, including mid-operation:
  - bin=0, adr=0, ptr=0, level=0, err=0.
  - status: 0 in PTR_WR, 1 in PTR_RD.
  - almost: 0 in PTR_WR, 1 in PTR_RD.
- No state machine. The only sequential state is the pointer pair plus the flag, level and error registers.

## Timing
- inc at edge N: adr, ptr, status, almost and level reflect it after edge N. Latency is 1 cycle, with no combinational path from inc to any output.
- A remote_gptr change is reflected in status/almost/level one edge later. That is the only added latency inside this block; synchroniser latency is external.
- Consecutive ptr values always differ in exactly one bit, including the wrap from 2*DEPTH-1 to 0.
- Simultaneous inc and remote_gptr change: both are folded into the same bnext/rbin computation. Example: a write at level 7 with a concurrent remote read gives level 7, not 8 then 7.
- Full-to-not-full and empty-to-not-empty deassertion is pessimistic by the synchroniser delay. This is intended and safe.
- Deassertion of rst_n is assumed synchronised externally. The block itself has no reset synchroniser.

## Structure
- Package fifo_ptr_pkg:
  - ptr_mode_e enum {PTR_WR, PTR_RD};
  - default ADDR_WIDTH localparam;
  - bin2gray function.
- Sub-module gray2bin #(WIDTH): combinational XOR-prefix converter. It is reused later by the FIFO top for debug level ports.
- The MODE-dependent compare is a generate branch. No duplicated pointer logic.

## Test plan
All scenarios use ADDR_WIDTH=3 (DEPTH 8, 4-bit pointers) and ALMOST_THRESH=2.
1. Reset: drive rst_n low for 3 cycles, release; then, after 5 writes (PTR_WR), pulse rst_n low mid-cycle -> all outputs return to reset values without waiting for clk; PTR_RD shows status=1, almost=1.
2. PTR_WR fill, remote_gptr=0000, inc held 8 cycles -> ptr sequence 0001,0011,0010,0110,0111,0101,0100,1100; almost rises when level=6; status=1 and level=8 after the 8th edge.
3. Overflow: PTR_WR at full, inc for 2 cycles -> ptr stays 1100, level stays 8, err=1. clr_err in the same cycle as another violating inc leaves err=1; clr_err alone -> err=0.
4. PTR_RD drain and wrap: remote_gptr=1100 (bin 8), 8 reads -> level 7..0, almost at level 2, empty after the 8th. Then set remote_gptr=0000 (bin 16 wrapped) and do 8 more reads -> ptr steps single-bit to 0000, empty=1.
5. Simultaneous events: PTR_WR at level 7 (bin 7, remote bin 0); one cycle with inc=1 and remote_gptr changed to bin 1 -> level=7, status stays 0.
6. Random inc/remote streams, checked against a reference model -> one-bit Gray changes only, level never above 8, status never deasserts without a remote_gptr change.
